// File: rtl/my_csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: CSR access, exception/interrupt
// entry, MRET, WFI sleep and registered PC redirects.
module my_csr_trap_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET = 'h100,
  parameter bit              VECTORED_EN = 1'b1,
  parameter logic [XLEN-1:0] MISA_VAL    = 'h4000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         csr_op_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [XLEN-1:0]    csr_wdata_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  output logic               csr_illegal_o,
  input  logic               exc_valid_i,
  input  logic [4:0]         exc_cause_i,
  input  logic [XLEN-1:0]    exc_pc_i,
  input  logic [XLEN-1:0]    exc_tval_i,
  input  logic               mret_i,
  input  logic               wfi_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               trap_o,
  output logic [XLEN-1:0]    trap_pc_o,
  output logic               stall_o,
  output logic               mie_o
);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMisa     = 12'h301;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;
  localparam logic [11:0] AddrMip      = 12'h344;
  localparam logic [11:0] AddrMcycle   = 12'hB00;
  localparam logic [11:0] AddrMcycleh  = 12'hB80;

  // Only the implemented local interrupt enables are writable.
  localparam logic [XLEN-1:0] MieMask = ((XLEN'(1) << NUM_IRQ) - XLEN'(1)) << 16;

  typedef enum logic {StRun, StSleep} state_e;

  state_e             r_state, w_state_d;
  logic               r_mstatus_mie, r_mstatus_mpie;
  logic [XLEN-1:0]    r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [63:0]        r_mcycle, w_mcycle_d;
  logic [NUM_IRQ-1:0] r_irq_q1, r_irq_q2;
  logic               r_trap;
  logic [XLEN-1:0]    r_trap_pc;

  logic [XLEN-1:0]    w_mip, w_rdata, w_new, w_pend, w_base, w_target, w_irq_mcause;
  logic               w_unimpl, w_illegal, w_pend_any, w_run;
  logic               w_exc, w_irq, w_mret, w_csr_we;
  logic [4:0]         w_irq_cause;
  logic [1:0]         w_mtvec_mode;

  // Synchronised interrupt lines mapped into mip[16 +: NUM_IRQ].
  always_comb begin
    w_mip = '0;
    w_mip[16 +: NUM_IRQ] = r_irq_q2;
  end

  // CSR read mux and address decode.
  always_comb begin
    w_rdata  = '0;
    w_unimpl = 1'b0;
    case (csr_addr_i)
      AddrMstatus: begin
        w_rdata[12:11] = 2'b11;
        w_rdata[7]     = r_mstatus_mpie;
        w_rdata[3]     = r_mstatus_mie;
      end
      AddrMisa:     w_rdata = MISA_VAL;
      AddrMie:      w_rdata = r_mie;
      AddrMtvec:    w_rdata = r_mtvec;
      AddrMscratch: w_rdata = r_mscratch;
      AddrMepc:     w_rdata = r_mepc;
      AddrMcause:   w_rdata = r_mcause;
      AddrMtval:    w_rdata = r_mtval;
      AddrMip:      w_rdata = w_mip;
      AddrMcycle:   w_rdata = r_mcycle[XLEN-1:0];
      AddrMcycleh: begin
        if (XLEN == 32) w_rdata[31:0] = r_mcycle[63:32];
        else            w_unimpl = 1'b1;
      end
      default:      w_unimpl = 1'b1;
    endcase
  end

  assign w_illegal     = w_unimpl || ((csr_op_i != 2'b00) && (csr_addr_i[11:10] == 2'b11));
  assign csr_rdata_o   = w_rdata;
  assign csr_illegal_o = w_illegal;

  // Read-modify-write value and WARL mtvec mode.
  always_comb begin
    case (csr_op_i)
      2'b10:   w_new = w_rdata | csr_wdata_i;
      2'b11:   w_new = w_rdata & ~csr_wdata_i;
      default: w_new = csr_wdata_i;
    endcase
    w_mtvec_mode = 2'b00;
    if ((w_new[1:0] == 2'b01) && VECTORED_EN) w_mtvec_mode = 2'b01;
  end

  // Interrupt arbitration: lowest pending index wins.
  always_comb begin
    w_pend       = w_mip & r_mie;
    w_pend_any   = |w_pend;
    w_irq_cause  = 5'd16;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (w_pend[16+i]) w_irq_cause = 5'(16 + i);
    end
    w_irq_mcause         = '0;
    w_irq_mcause[XLEN-1] = 1'b1;
    w_irq_mcause[4:0]    = w_irq_cause;
  end

  // Event priority: exception > interrupt > MRET > CSR write.
  assign w_run    = (r_state == StRun);
  assign w_exc    = w_run && exc_valid_i;
  assign w_irq    = r_mstatus_mie && w_pend_any && !w_exc;
  assign w_mret   = w_run && mret_i && !w_exc && !w_irq;
  assign w_csr_we = (csr_op_i != 2'b00) && !w_illegal && !w_exc && !w_irq && !w_mret;

  // Redirect target selection.
  always_comb begin
    w_base = {r_mtvec[XLEN-1:2], 2'b00};
    if (w_mret)                                 w_target = r_mepc;
    else if (w_irq && (r_mtvec[1:0] == 2'b01))  w_target = w_base + (XLEN'(w_irq_cause) << 2);
    else if (w_exc || w_irq)                    w_target = w_base;
    else                                        w_target = '0;
  end

  // Cycle counter next value; an explicit write holds off the increment.
  always_comb begin
    w_mcycle_d = r_mcycle + 64'd1;
    if (w_csr_we && (csr_addr_i == AddrMcycle)) begin
      w_mcycle_d              = r_mcycle;
      w_mcycle_d[XLEN-1:0]    = w_new;
    end
    if (w_csr_we && (csr_addr_i == AddrMcycleh)) begin
      w_mcycle_d              = r_mcycle;
      w_mcycle_d[63:32]       = w_new[31:0];
    end
  end

  // Sleep FSM next state; SLEEP wakes on any enabled pending line, even with MIE clear.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StRun:   if (wfi_i && !w_exc && !w_irq && !w_mret && !w_pend_any) w_state_d = StSleep;
      StSleep: if (w_pend_any) w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  // State, CSR storage, synchroniser and registered redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StRun;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= MTVEC_RESET;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mcycle       <= '0;
      r_irq_q1       <= '0;
      r_irq_q2       <= '0;
      r_trap         <= 1'b0;
      r_trap_pc      <= '0;
    end else begin
      r_state   <= w_state_d;
      r_mcycle  <= w_mcycle_d;
      r_irq_q1  <= irq_i;
      r_irq_q2  <= r_irq_q1;
      r_trap    <= w_exc || w_irq || w_mret;
      r_trap_pc <= w_target;
      if (w_exc || w_irq) begin
        r_mepc         <= exc_pc_i & ~XLEN'(3);
        r_mcause       <= w_exc ? XLEN'(exc_cause_i) : w_irq_mcause;
        r_mtval        <= w_exc ? exc_tval_i : '0;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_csr_we) begin
        case (csr_addr_i)
          AddrMstatus: begin
            r_mstatus_mie  <= w_new[3];
            r_mstatus_mpie <= w_new[7];
          end
          AddrMie:      r_mie      <= w_new & MieMask;
          AddrMtvec:    r_mtvec    <= {w_new[XLEN-1:2], w_mtvec_mode};
          AddrMscratch: r_mscratch <= w_new;
          AddrMepc:     r_mepc     <= w_new & ~XLEN'(3);
          AddrMcause:   r_mcause   <= w_new;
          AddrMtval:    r_mtval    <= w_new;
          default: ;
        endcase
      end
    end
  end

  assign trap_o    = r_trap;
  assign trap_pc_o = r_trap_pc;
  assign stall_o   = (r_state == StSleep);
  assign mie_o     = r_mstatus_mie;

endmodule

// File: tb/tb_my_csr_trap_unit.sv
// Scoreboard bench for my_csr_trap_unit: stimulus queues expected reads and
// redirects, a negedge monitor pops and compares them.
module tb_my_csr_trap_unit;

  logic        clk, rst_n;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_illegal;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret, wfi;
  logic [3:0]  irq;
  logic        trap_o;
  logic [31:0] trap_pc;
  logic        stall, mie_o;

  my_csr_trap_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_op_i     (csr_op),
    .csr_addr_i   (csr_addr),
    .csr_wdata_i  (csr_wdata),
    .csr_rdata_o  (csr_rdata),
    .csr_illegal_o(csr_illegal),
    .exc_valid_i  (exc_valid),
    .exc_cause_i  (exc_cause),
    .exc_pc_i     (exc_pc),
    .exc_tval_i   (exc_tval),
    .mret_i       (mret),
    .wfi_i        (wfi),
    .irq_i        (irq),
    .trap_o       (trap_o),
    .trap_pc_o    (trap_pc),
    .stall_o      (stall),
    .mie_o        (mie_o)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] exp;
  } rd_t;

  rd_t         rd_q[$];
  logic [31:0] trap_q[$];
  logic        rd_vld;
  int          n_vec  = 0;
  int          n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_vld) begin
        rd_t e;
        e = rd_q.pop_front();
        n_vec++;
        if (csr_rdata !== e.exp) begin
          n_fail++;
          $display("FAIL rd_%h: got %h expected %h", e.addr, csr_rdata, e.exp);
        end
      end
      if (trap_o) begin
        n_vec++;
        if (trap_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_trap: got trap_pc %h expected no redirect", trap_pc);
        end else begin
          logic [31:0] t;
          t = trap_q.pop_front();
          if (trap_pc !== t) begin
            n_fail++;
            $display("FAIL trap_pc: got %h expected %h", trap_pc, t);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance one clock; single-cycle pulses drop right after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    csr_op    = 2'b00;
    exc_valid = 1'b0;
    mret      = 1'b0;
    wfi       = 1'b0;
    rd_vld    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = d;
    cyc();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    csr_addr = a;
    rd_vld   = 1'b1;
    rd_q.push_back({a, e});
    cyc();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; csr_op = 2'b00; csr_addr = 12'h300; csr_wdata = '0; rd_vld = 1'b0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret = 1'b0; wfi = 1'b0; irq = '0;
    #12;
    chk("rst_trap_o", {31'd0, trap_o}, 32'd0);
    chk("rst_stall_o", {31'd0, stall}, 32'd0);
    #10 rst_n = 1'b1;
    cyc();

    // Reset values
    rd(12'h305, 32'h100);
    rd(12'h301, 32'h4000_0100);
    rd(12'h300, 32'h1800);
    rd(12'h304, 32'h0);
    rd(12'h341, 32'h0);

    // Exception entry and MRET
    wr(2'b10, 12'h300, 32'h8);
    rd(12'h300, 32'h1808);
    exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h200; exc_tval = 32'h55;
    trap_q.push_back(32'h100);
    cyc();
    rd(12'h341, 32'h200);
    rd(12'h342, 32'hB);
    rd(12'h343, 32'h55);
    rd(12'h300, 32'h1880);
    mret = 1'b1;
    trap_q.push_back(32'h200);
    cyc();
    rd(12'h300, 32'h1888);
    chk("mie_o", {31'd0, mie_o}, 32'd1);

    // Vectored interrupt
    wr(2'b01, 12'h305, 32'h301);
    rd(12'h305, 32'h301);
    wr(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd(12'h304, 32'h000F_0000);
    wr(2'b01, 12'h304, 32'h0002_0000);
    exc_pc = 32'h400;
    irq    = 4'b0010;
    trap_q.push_back(32'h344);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (trap_o) begin
        lat = n;
        break;
      end
    end
    chk("irq_latency", lat, 32'd3);
    rd(12'h342, 32'h8000_0011);
    rd(12'h341, 32'h400);
    rd(12'h343, 32'h0);
    rd(12'h344, 32'h0002_0000);
    rd(12'h300, 32'h1880);
    irq = '0;
    idle(3);

    // Simultaneous exception, interrupt, MRET and CSR write
    mret = 1'b1;
    trap_q.push_back(32'h400);
    cyc();
    irq = 4'b0010;
    idle(2);
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h500; exc_tval = 32'h77;
    mret = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hDEAD;
    trap_q.push_back(32'h300);
    cyc();
    rd(12'h340, 32'h0);
    rd(12'h342, 32'h2);
    rd(12'h341, 32'h500);
    rd(12'h300, 32'h1880);
    irq = '0;
    idle(3);

    // WFI sleep with MIE clear, exception ignored while asleep
    wr(2'b01, 12'h304, 32'h0001_0000);
    wfi = 1'b1;
    cyc();
    chk("stall_enter", {31'd0, stall}, 32'd1);
    exc_valid = 1'b1; exc_cause = 5'd3; exc_pc = 32'h700;
    cyc();
    chk("stall_exc", {31'd0, stall}, 32'd1);
    irq = 4'b0001;
    idle(2);
    chk("stall_sync", {31'd0, stall}, 32'd1);
    cyc();
    chk("stall_wake", {31'd0, stall}, 32'd0);
    rd(12'h342, 32'h2);
    rd(12'h344, 32'h0001_0000);
    irq = '0;
    idle(3);

    // mcycle wrap into mcycleh
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB80, 32'h1);

    // Illegal accesses and WARL fields
    csr_op = 2'b01; csr_addr = 12'hC00; csr_wdata = 32'h1234;
    #1 chk("illegal_c00", {31'd0, csr_illegal}, 32'd1);
    cyc();
    csr_addr = 12'h7C0;
    #1 chk("illegal_7c0", {31'd0, csr_illegal}, 32'd1);
    csr_addr = 12'h300;
    #1 chk("legal_300", {31'd0, csr_illegal}, 32'd0);
    wr(2'b01, 12'h341, 32'h203);
    rd(12'h341, 32'h200);
    wr(2'b01, 12'h305, 32'h402);
    rd(12'h305, 32'h400);
    wr(2'b01, 12'h301, 32'h0);
    rd(12'h301, 32'h4000_0100);
    wr(2'b01, 12'h344, 32'hFFFF_FFFF);
    rd(12'h344, 32'h0);
    wr(2'b11, 12'h300, 32'h80);
    rd(12'h300, 32'h1800);

    // Reset during a pending redirect
    exc_valid = 1'b1; exc_cause = 5'd0; exc_pc = 32'h600;
    @(posedge clk);
    #1;
    exc_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk("rst_mid_trap", {31'd0, trap_o}, 32'd0);
    #5 rst_n = 1'b1;
    cyc();

    // Reset during sleep
    wr(2'b01, 12'h304, 32'h0001_0000);
    wfi = 1'b1;
    cyc();
    chk("stall_pre_rst", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    #5 rst_n = 1'b1;
    cyc();
    rd(12'h304, 32'h0);
    rd(12'h305, 32'h100);
    rd(12'h300, 32'h1800);

    for (int i = 0; i < 20 && trap_q.size() != 0; i++) cyc();
    n_vec++;
    if (trap_q.size() != 0) begin
      n_fail++;
      $display("FAIL trap_drain: got %0d outstanding redirects expected 0", trap_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/my_csr_trap_unit.md
Name: my_csr_trap_unit

Overview:
Machine-mode CSR file and trap sequencer for the RISC-V core. It is a parametrised successor to the fixed CSR/exception constant set. It adds XLEN and interrupt-line-count parameters, vectored mtvec mode, an mcycle counter, WFI sleep and interrupt arbitration. It sits beside the execute/writeback stage, services CSR instructions, and issues registered PC redirects for exceptions, interrupts and MRET.

Parameters:
XLEN, 32, data width; legal values 32 or 64.
NUM_IRQ, 4, local interrupt lines; line i has cause 16+i; range 1..16.
MTVEC_RESET, 'h100, reset value of mtvec (direct mode).
VECTORED_EN, 1, 1 = mtvec mode 01 is supported; 0 = mode is forced to 00.
MISA_VAL, 'h4000_0100, read-only misa contents (RV32I).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
csr_op_i  in  2  00 none, 01 RW, 10 RS, 11 RC
csr_addr_i  in  12  CSR address
csr_wdata_i  in  XLEN  write operand (rs1 or uimm)
csr_rdata_o  out  XLEN  combinational old value of the addressed CSR
csr_illegal_o  out  1  combinational; unimplemented address, or write to read-only space
exc_valid_i  in  1  synchronous exception this cycle
exc_cause_i  in  5  exception cause (0, 2, 11, ...)
exc_pc_i  in  XLEN  PC of the faulting instruction; also the resume PC on interrupt
exc_tval_i  in  XLEN  trap value
mret_i  in  1  MRET retiring
wfi_i  in  1  WFI retiring
irq_i  in  NUM_IRQ  asynchronous level interrupt lines
trap_o  out  1  one-cycle redirect strobe
trap_pc_o  out  XLEN  redirect target, valid while trap_o = 1
stall_o  out  1  high while sleeping in WFI
mie_o  out  1  mstatus.MIE

Behaviour:
- Reset values: trap_o=0, trap_pc_o=0, stall_o=0. mstatus.MIE=0, mstatus.MPIE=0. mtvec=MTVEC_RESET. mie, mip, mscratch, mepc, mcause, mtval, mcycle all 0. FSM state = RUN.
- Reset asserted mid-operation clears everything in the same instant, including a pending redirect or an active sleep.
- irq_i passes through a 2-flop synchroniser into mip bits 16+i.
- An interrupt is visible 2 cycles after irq_i rises; mip is read-only, writes to it are ignored.
- CSR addresses: 300 mstatus, 301 misa, 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 343 mtval, 344 mip, B00 mcycle.
- B80 mcycleh exists only when XLEN=32; otherwise the address is illegal.
- Read-only fields: mstatus.MPP reads 2'b11; all other mstatus bits except MIE(3) and MPIE(7) read 0.
- New value = RW: wdata; RS: old|wdata; RC: old&~wdata. The write commits on the next clock edge.
- WARL rules: mepc[1:0] is forced to 0. mtvec mode values 1x are stored as 00; mode 01 is stored as 00 when VECTORED_EN=0. Writes to misa are ignored. mie keeps only bits 16..16+NUM_IRQ-1.
- csr_illegal_o=1 for an unimplemented address, or for a write op (any nonzero op) with addr[11:10]=2'b11. An illegal access changes no state.
- mcycle increments every cycle, including during sleep. A CSR write to mcycle/mcycleh in the same cycle wins over the increment.
- Event priority (highest first): exc_valid_i > pending interrupt > mret_i > CSR write. A lower-priority event in the same cycle is discarded.
- Pending interrupt = mie_o && |(mip & mie). The lowest index wins.
- Trap entry: mepc<=exc_pc_i. mcause<={isIrq, cause zero-extended}. mtval<=exc_tval_i (0 for an interrupt). MPIE<=MIE, MIE<=0.
- Trap target: base = {mtvec[XLEN-1:2],2'b00}. Vectored mode (01) with an interrupt gives base + 4*cause; otherwise base.
- MRET: MIE<=MPIE, MPIE<=1, target = mepc.
- Redirect timing: trap_o and trap_pc_o are registered and high for exactly the cycle after the event. At most one redirect is issued per cycle.
- FSM:
  - RUN: wfi_i with no pending event moves to SLEEP and sets stall_o=1 on the next cycle.
  - SLEEP: exits to RUN when |(mip & mie), regardless of MIE, and stall_o drops the following cycle.
  - On exit from SLEEP, if MIE=1 the interrupt trap is taken on that same exit edge.
  - exc_valid_i while in SLEEP is ignored.

Test Plan:
- Reset, then read 305 -> 'h100. Read 301 -> MISA_VAL. Read 300 -> 'h1800. trap_o=0, stall_o=0.
- RS 300 with 'h8 sets MIE. Then exc_valid_i with cause 11, pc 'h200 -> next cycle trap_o=1, trap_pc_o='h100, mepc='h200, mcause=11, MIE=0, MPIE=1. Then mret_i -> trap_o=1, trap_pc_o='h200, MIE=1.
- RW mtvec 'h301, mie bit17 set, MIE=1, raise irq_i[1] -> redirect 3 cycles later: trap_pc_o='h300+4*17='h344, mcause='h8000_0011.
- exc_valid_i, mret_i and irq pending in the same cycle -> exception target only; a CSR RW issued in the same cycle is not committed.
- wfi_i with MIE=0 and mie bit16 set -> stall_o=1. Raise irq_i[0] -> stall_o=0, no trap_o.
- Write 'hFFFF_FFFF to B00 -> next cycle reads 'hFFFF_FFFF, then B80 increments by 1 on wrap. Write to 'hC00 -> csr_illegal_o=1 and no state change.
